// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier, restoring divider.
// Latency: 33 cycles start->done (DATA_WIDTH iterations + FIN); 1 cycle for div-by-zero / signed overflow.
// Backpressure: none; busy stays high until done, and start is ignored unless the unit is idle.
// Ports: clk, rst_n (async, active-low); start/funct3/op_a/op_b request (sampled only in IDLE);
//        busy while an operation is in flight; done 1-cycle pulse with result (held until next done).
module riscv_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST    = CW'(W - 1);

  logic [1:0]     state_q, state_d;
  logic [2:0]     f3_q, f3_d;
  logic           neg_res_q, neg_res_d;   // negate product / quotient in FIN
  logic           neg_rem_q, neg_rem_d;   // remainder takes dividend sign
  logic [W-1:0]   opnd_q, opnd_d;         // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*W-1:0] acc_q, acc_d;           // MUL: product:multiplier, DIV: remainder:quotient
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;

  // Operand decode, evaluated in IDLE
  logic         a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0] mag_a, mag_b;

  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed & op_a[W-1];
  assign b_neg    = b_signed & op_b[W-1];
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b    = b_neg ? -op_b : op_b;
  assign div_zero = funct3[2] && (op_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);

  // Iteration datapath
  logic [W:0]   mul_sum;
  logic [W:0]   div_rem_sh;
  logic [W+1:0] div_trial;
  logic         div_ge;

  assign mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  // Shifted remainder can need W+1 bits when the divisor is close to 2^W.
  assign div_rem_sh = acc_q[2*W-1:W-1];
  assign div_trial  = {1'b0, div_rem_sh} - {2'b00, opnd_q};
  // A non-negative trial difference is always below 2^W, so both top bits are zero.
  assign div_ge     = (div_trial[W+1:W] == 2'b00);

  // Sign fix-up and result selection
  logic [2*W-1:0] fin_prod;
  logic [W-1:0]   fin_quo, fin_rem, fin_sel;

  assign fin_prod = neg_res_q ? -acc_q : acc_q;
  assign fin_quo  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign fin_rem  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    case (f3_q)
      3'b000:                 fin_sel = fin_prod[W-1:0];
      3'b001, 3'b010, 3'b011: fin_sel = fin_prod[2*W-1:W];
      3'b100, 3'b101:         fin_sel = fin_quo;
      default:                fin_sel = fin_rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          cnt_d = '0;
          if (div_zero) begin
            // Preload the architectural answer and skip sign fix-up.
            acc_d     = {op_a, {W{1'b1}}};
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIN;
          end else if (div_ovf) begin
            acc_d     = {{W{1'b0}}, MIN_NEG};
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIN;
          end else if (funct3[2]) begin
            acc_d     = {{W{1'b0}}, mag_a};
            opnd_d    = mag_b;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = S_DIV;
          end else begin
            acc_d     = {{W{1'b0}}, mag_b};
            opnd_d    = mag_a;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = 1'b0;
            state_d   = S_MUL;
          end
        end
      end
      S_MUL: begin
        // Carry out of the add becomes the new top bit after the shift.
        acc_d = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIN;
      end
      S_DIV: begin
        acc_d = div_ge ? {div_trial[W-1:0], acc_q[W-2:0], 1'b1}
                       : {div_rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIN;
      end
      S_FIN: begin
        result_d = fin_sel;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv: directed RV32M cases plus randomized ops
// compared against a plain-arithmetic reference model; start noise, back-to-back and reset abort.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_muldiv #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f)
      3'b000: begin up = ua * ub;           r = up[31:0];  end
      3'b001: begin sp = sa * sb;           r = sp[63:32]; end
      3'b010: begin sp = sa * $signed(ub);  r = sp[63:32]; end
      3'b011: begin up = ua * ub;           r = up[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin sp = sa / sb; r = sp[31:0]; end
      end
      3'b101: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin sp = sa % sb; r = sp[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present a request for one edge, then scramble the operand inputs.
  task automatic launch(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    check({tag, ".busy_e0"}, {31'b0, busy}, 32'd1);
  endtask

  // Wait for done (bounded); optionally toggle start with junk operands while busy.
  task automatic finish_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input bit noise);
    int lat;
    bit busy_bad;
    lat = 0;
    busy_bad = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, ref_latency(f, a, b));
    check({tag, ".result"}, result, ref_result(f, a, b));
    check({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, ".busy_run"}, {31'b0, busy_bad}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit noise);
    launch(tag, f, a, b);
    finish_op(tag, f, a, b, noise);
  endtask

  logic [2:0]  dir_f [10] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                              3'b101, 3'b111, 3'b101, 3'b110, 3'b100};
  logic [31:0] dir_a [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234,
                              32'h8000_0000};
  logic [31:0] dir_b [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b, held;
    bit          ghost;

    // Reset state
    #2;
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -3, then result must hold with done low
    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    held = ref_result(3'b000, 32'd7, 32'hFFFF_FFFD);
    @(posedge clk);
    #1;
    check("mul.done_pulse", {31'b0, done}, 32'd0);
    check("mul.held", result, held);

    // Directed ops issued back-to-back in each done cycle
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("dir%0d", i), dir_f[i], dir_a[i], dir_b[i], 1'b0);
    end

    // Start pulses with other operands while busy are ignored
    do_op("noise_div", 3'b100, 32'd1000, 32'd7, 1'b1);
    do_op("noise_mulh", 3'b001, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);

    // Reset during iteration 10 aborts with no done pulse
    launch("abort", 3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.done", {31'b0, done}, 32'd0);
    check("abort.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ghost = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) ghost = 1'b1;
    end
    check("abort.no_done", {31'b0, ghost}, 32'd0);
    do_op("after_abort", 3'b011, 32'hFFFF_0001, 32'h0001_FFFF, 1'b0);

    // Randomized ops with biased corner operands
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: ;
      endcase
      do_op($sformatf("rnd%0d", i), f, a, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU operand muxes: it consumes operand A from the first ALU mux and operand B (register rs2 or immediate) from the second ALU mux, and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It uses a radix-2 shift-add multiplier and a restoring divider, 32 iterations each, behind a start/busy/done handshake so the core stalls while it runs. Divide-by-zero and signed overflow bypass the iteration loop.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  DATA_WIDTH  operand A (rs1 path); multiplicand/dividend.
- op_b  input  DATA_WIDTH  operand B from ALU mux 2; multiplier/divisor.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse; result valid.
- result  output  DATA_WIDTH  result, held until next done.

## Operation
- States: IDLE, MUL, DIV, FIN.
- IDLE: on start=1 latch funct3, sign flags and magnitudes of op_a/op_b (signed ops take two's-complement absolute value; MULHSU: A signed, B unsigned; MULHU/DIVU/REMU: both unsigned), clear 64-bit accumulator and 5-bit iteration counter; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Special cases detected in IDLE, go straight to FIN: divisor 0 -> quotient all-ones, remainder = op_a unmodified; signed DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- MUL: per cycle, if multiplier LSB=1 add multiplicand into accumulator upper half, shift right 1 (33-bit carry kept); after 32 iterations go to FIN.
- DIV: per cycle, shift remainder:quotient left 1, trial-subtract divisor from remainder; if non-negative keep and set quotient LSB; after 32 iterations go to FIN.
- FIN: apply sign: product negated (64-bit) if signs differ; quotient negated if signs differ; remainder takes dividend sign. Select low word (MUL), high word (MULH*), quotient or remainder; register result, pulse done, return to IDLE.
- start while busy or in FIN ignored; operands need only be valid in the start cycle.

## Timing
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, counter/accumulator cleared. Reset mid-operation aborts with no done pulse.
- Normal op: start sampled at edge E0; busy=1 from E0; iterations at E1..E32; FIN evaluated E33: done=1, busy=0, result updated for exactly one cycle after E33 (33-cycle latency).
- Special case: start at E0 -> FIN at E1: done=1 after E1 (1-cycle latency); busy high for one cycle.
- Back-to-back: start may be asserted in the cycle done=1 (unit is IDLE then) and is accepted.
- done never asserts without a preceding accepted start; result changes only on done edge.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD -> done exactly 33 cycles after start, result 0xFFFFFFEB; busy high for cycles 1-32 and low with done.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234, both done 1 cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, 1 cycle.
- Start pulses during busy with different operands -> ignored, original result returned; new start in done cycle accepted and completes 33 cycles later.
- rst_n low at iteration 10 -> busy=0, done=0, result=0 immediately; no done pulse follows; next start completes normally.
